// File: rtl/lsu_rmw.sv
// Load/store unit between the CPU memory stage and a word-wide data memory: sub-word stores
// use read-modify-write, loads are lane-selected and extended. Build option: LSU_BOUNDS_CHECK_EN.
module lsu_rmw #(
  parameter int MEM_WORDS = 32
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWdata,
  output logic        oReady,
  output logic        oValid,
  output logic        oErr,
  output logic [31:0] oRdata,
  output logic [31:0] oMemAddr,
  output logic        oMemWe,
  output logic [31:0] oMemWdata,
  input  logic [31:0] iMemRdata,
  output logic [1:0]  oDbgState
);

  // Handshake: a request transfers on the posedge where iReq && oReady; oReady is high only in
  // IDLE, the CPU holds iReq until then, and oValid (qualified by oErr) pulses once per access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        valid_q;
  logic        err_q;
  logic        mem_we_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_wdata_q;

  logic        f3_bad_d;
  logic        align_bad_d;
  logic        range_bad_d;
  logic        acc_err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_data_d;
  logic [31:0] rmw_word_d;

  always_comb begin
    f3_bad_d = 1'b0;
    case (iFunct3)
      3'b000, 3'b001, 3'b010: f3_bad_d = 1'b0;
      3'b100, 3'b101:         f3_bad_d = iWe;
      default:                f3_bad_d = 1'b1;
    endcase
    align_bad_d = ((iFunct3[1:0] == 2'b01) && iAddr[0]) ||
                  ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));
`ifdef LSU_BOUNDS_CHECK_EN
    range_bad_d = ({2'b00, iAddr[31:2]} >= 32'(MEM_WORDS));
`else
    // No range check: dmem wraps the address; only an empty memory rejects everything.
    range_bad_d = (MEM_WORDS < 1);
`endif
    acc_err_d = f3_bad_d || align_bad_d || range_bad_d;
  end

  always_comb begin
    byte_d = 8'h00;
    case (addr_q[1:0])
      2'b00: byte_d = iMemRdata[7:0];
      2'b01: byte_d = iMemRdata[15:8];
      2'b10: byte_d = iMemRdata[23:16];
      2'b11: byte_d = iMemRdata[31:24];
      default: byte_d = 8'h00;
    endcase
    half_d = addr_q[1] ? iMemRdata[31:16] : iMemRdata[15:0];

    load_data_d = iMemRdata;
    case (funct3_q)
      3'b000:  load_data_d = {{24{byte_d[7]}}, byte_d};
      3'b001:  load_data_d = {{16{half_d[15]}}, half_d};
      3'b100:  load_data_d = {24'h000000, byte_d};
      3'b101:  load_data_d = {16'h0000, half_d};
      default: load_data_d = iMemRdata;
    endcase
  end

  // Store lane merge: only the addressed byte/half is replaced, the rest comes from dmem.
  always_comb begin
    rmw_word_d = iMemRdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00: rmw_word_d[7:0]   = wdata_q[7:0];
        2'b01: rmw_word_d[15:8]  = wdata_q[7:0];
        2'b10: rmw_word_d[23:16] = wdata_q[7:0];
        2'b11: rmw_word_d[31:24] = wdata_q[7:0];
        default: rmw_word_d = iMemRdata;
      endcase
    end else if (addr_q[1]) begin
      rmw_word_d[31:16] = wdata_q[15:0];
    end else begin
      rmw_word_d[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      rdata_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iReq) begin
            we_q     <= iWe;
            funct3_q <= iFunct3;
            addr_q   <= iAddr;
            wdata_q  <= iWdata;
            if (acc_err_d) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (iWe && (iFunct3[1:0] == 2'b10)) begin
              state_q     <= WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= iWdata;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= rmw_word_d;
          end else begin
            state_q <= DONE;
            valid_q <= 1'b1;
            rdata_q <= load_data_d;
          end
        end
        WR: begin
          state_q <= DONE;
          valid_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oReady    = (state_q == IDLE);
  assign oValid    = valid_q;
  assign oErr      = err_q;
  assign oRdata    = rdata_q;
  assign oMemWdata = mem_wdata_q;
  assign oMemAddr  = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
  // A reset arriving during WR must stop the write at the very edge dmem would commit it.
  assign oMemWe    = mem_we_q & iReset_n;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word-array dmem model and hand-computed expectations.
module tb_lsu_rmw;

  logic        iClk;
  logic        iReset_n;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWdata;
  logic        oReady;
  logic        oValid;
  logic        oErr;
  logic [31:0] oRdata;
  logic [31:0] oMemAddr;
  logic        oMemWe;
  logic [31:0] oMemWdata;
  logic [31:0] iMemRdata;
  logic [1:0]  oDbgState;

  logic [31:0] mem [32];
  logic        mem_init;
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  lsu_rmw #(.MEM_WORDS(32)) dut (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .iReq      (iReq),
    .iWe       (iWe),
    .iFunct3   (iFunct3),
    .iAddr     (iAddr),
    .iWdata    (iWdata),
    .oReady    (oReady),
    .oValid    (oValid),
    .oErr      (oErr),
    .oRdata    (oRdata),
    .oMemAddr  (oMemAddr),
    .oMemWe    (oMemWe),
    .oMemWdata (oMemWdata),
    .iMemRdata (iMemRdata),
    .oDbgState (oDbgState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // dmem model: combinational read, write on posedge, wraps modulo 32 words
  assign iMemRdata = mem[oMemAddr[6:2]];
  always @(posedge iClk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h13579BDF;
      mem[2] <= 32'h882244F0;
    end else if (oMemWe) begin
      mem[oMemAddr[6:2]] <= oMemWdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver: one access, returns latency (cycles after accept edge) and what dmem saw
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic err,
                        output logic [31:0] rdata, output int we_cnt, output int we_at,
                        output logic [31:0] we_data, output logic [31:0] addr1);
    int n;
    @(negedge iClk);
    iReq = 1'b1; iWe = we; iFunct3 = f3; iAddr = addr; iWdata = wdata;
    n = 0;
    while (!oReady && n < 20) begin
      @(negedge iClk);
      n++;
    end
    @(negedge iClk);
    iReq = 1'b0;
    iWe = 1'($urandom_range(0, 1));
    iFunct3 = 3'($urandom_range(0, 7));
    iAddr = $urandom;
    iWdata = $urandom;
    lat = 1; we_cnt = 0; we_at = 0; we_data = 32'h0;
    addr1 = oMemAddr;
    while (!oValid && lat < 20) begin
      if (oMemWe) begin
        we_cnt++; we_at = lat; we_data = oMemWdata;
      end
      @(negedge iClk);
      lat++;
    end
    if (oMemWe) we_cnt++;
    err = oErr;
    rdata = oRdata;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_data);
    int lat, we_cnt, we_at;
    logic err;
    logic [31:0] rdata, we_data, addr1;
    exp_q.push_back(exp_data);
    access(1'b0, f3, addr, 32'h0, lat, err, rdata, we_cnt, we_at, we_data, addr1);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, {31'h0, err}, 32'd0);
    chk({tag, "_data"}, rdata, exp_q.pop_front());
    chk({tag, "_nowe"}, 32'(we_cnt), 32'd0);
    chk({tag, "_maddr"}, addr1, {addr[31:2], 2'b00});
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat, input int exp_we_at,
                           input logic [31:0] exp_word);
    int lat, we_cnt, we_at;
    logic err;
    logic [31:0] rdata, we_data, addr1;
    logic [31:0] rdata_before;
    rdata_before = oRdata;
    access(1'b1, f3, addr, wdata, lat, err, rdata, we_cnt, we_at, we_data, addr1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, {31'h0, err}, 32'd0);
    chk({tag, "_wecnt"}, 32'(we_cnt), 32'd1);
    chk({tag, "_weat"}, 32'(we_at), 32'(exp_we_at));
    chk({tag, "_wdata"}, we_data, exp_word);
    chk({tag, "_rdata_kept"}, rdata, rdata_before);
  endtask

  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp_rdata);
    int lat, we_cnt, we_at;
    logic err;
    logic [31:0] rdata, we_data, addr1;
    access(we, f3, addr, 32'hFFFF_FFFF, lat, err, rdata, we_cnt, we_at, we_data, addr1);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, {31'h0, err}, 32'd1);
    chk({tag, "_nowe"}, 32'(we_cnt), 32'd0);
    chk({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    int lat, we_cnt, we_at, n;
    logic err;
    logic [31:0] rdata, we_data, addr1;
    n_checks = 0; n_pass = 0;
    iReset_n = 1'b0; mem_init = 1'b1;
    iReq = 1'b0; iWe = 1'b0; iFunct3 = 3'b000; iAddr = 32'h0; iWdata = 32'h0;
    repeat (3) @(negedge iClk);
    iReset_n = 1'b1; mem_init = 1'b0;

    chk("rst_ready", {31'h0, oReady}, 32'd1);
    chk("rst_valid", {31'h0, oValid}, 32'd0);
    chk("rst_err", {31'h0, oErr}, 32'd0);
    chk("rst_rdata", oRdata, 32'h0);
    chk("rst_maddr", oMemAddr, 32'h0);
    chk("rst_mwe", {31'h0, oMemWe}, 32'd0);
    chk("rst_mwdata", oMemWdata, 32'h0);

    run_load("lw08", 3'b010, 32'h08, 32'h882244F0);
    run_load("lb0b", 3'b000, 32'h0B, 32'hFFFFFF88);
    run_load("lbu0b", 3'b100, 32'h0B, 32'h00000088);
    run_load("lh08", 3'b001, 32'h08, 32'h000044F0);
    run_load("lh0a", 3'b001, 32'h0A, 32'hFFFF8822);
    run_load("lhu0a", 3'b101, 32'h0A, 32'h00008822);
    run_load("lb09", 3'b000, 32'h09, 32'h00000044);

    run_store("sb09", 3'b000, 32'h09, 32'h000000AB, 3, 2, 32'h8822ABF0);
    chk("sb09_mem", mem[2], 32'h8822ABF0);
    run_store("sh0a", 3'b001, 32'h0A, 32'h00001234, 3, 2, 32'h1234ABF0);
    chk("sh0a_mem", mem[2], 32'h1234ABF0);
    run_store("sw0c", 3'b010, 32'h0C, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF);
    @(negedge iClk);
    chk("ready_after_done", {31'h0, oReady}, 32'd1);
    run_load("lw0c", 3'b010, 32'h0C, 32'hDEADBEEF);

    run_err("lw06", 1'b0, 3'b010, 32'h06, 32'hDEADBEEF);
    run_err("sh03", 1'b1, 3'b001, 32'h03, 32'hDEADBEEF);
    run_err("f3_011", 1'b0, 3'b011, 32'h08, 32'hDEADBEEF);
    run_err("sbu", 1'b1, 3'b100, 32'h08, 32'hDEADBEEF);
    chk("err_mem2", mem[2], 32'h1234ABF0);

    // reset in the WR cycle of an SB
    @(negedge iClk);
    iReq = 1'b1; iWe = 1'b1; iFunct3 = 3'b000; iAddr = 32'h08; iWdata = 32'h00000055;
    n = 0;
    while (!oMemWe && n < 10) begin
      @(negedge iClk);
      iReq = 1'b0;
      n++;
    end
    chk("rmw_reached_wr", {31'h0, oMemWe}, 32'd1);
    iReset_n = 1'b0;
    #1;
    chk("rst_wr_mwe", {31'h0, oMemWe}, 32'd0);
    @(negedge iClk);
    iReset_n = 1'b1;
    chk("rst_wr_ready", {31'h0, oReady}, 32'd1);
    chk("rst_wr_rdata", oRdata, 32'h0);
    chk("rst_wr_mem2", mem[2], 32'h1234ABF0);
    run_load("lw08_post", 3'b010, 32'h08, 32'h1234ABF0);

`ifdef LSU_BOUNDS_CHECK_EN
    run_err("lw80_oob", 1'b0, 3'b010, 32'h80, 32'h1234ABF0);
`else
    run_load("lw80_wrap", 3'b010, 32'h80, 32'h13579BDF);
`endif

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
